// File: rtl/mdu_ctrl.sv
// Multiply/divide scheduler owning HI/LO; holds busy for a fixed latency per op.
// Latency: MULT_CYCLES / DIV_CYCLES after issue to HI/LO commit; MTHI/MTLO commit at the issue edge.
// Backpressure: stall (combinational) holds the pipeline; starts while busy are ignored.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    ph;
    logic [31:0]    pl;

    logic           go;
    logic           is_signed;
    logic [63:0]    mul_a;
    logic [63:0]    mul_b;
    logic [63:0]    prod;
    logic [31:0]    a_mag;
    logic [31:0]    b_mag;
    logic [31:0]    dvd;
    logic [31:0]    dvs;
    logic [31:0]    uq;
    logic [31:0]    ur;
    logic [31:0]    quo;
    logic [31:0]    rem;
    logic           div_zero;

    assign go    = start & ~flush & ~busy;
    assign stall = busy | (start & ~flush & ~MDOp[2]);

    // Shared multiplier and divider datapath; MDOp[0] selects unsigned for both.
    always_comb begin
        is_signed = ~MDOp[0];
        mul_a     = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
        mul_b     = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
        prod      = mul_a * mul_b;

        // Divide magnitudes unsigned, then restore signs: quotient truncates
        // toward zero, remainder follows the dividend.  0x80000000 magnitude
        // is itself, so the overflow case yields quotient 0x80000000 naturally.
        a_mag     = A[31] ? (~A + 32'd1) : A;
        b_mag     = B[31] ? (~B + 32'd1) : B;
        dvd       = is_signed ? a_mag : A;
        dvs       = is_signed ? b_mag : B;
        div_zero  = (B == 32'd0);
        if (div_zero) begin
            dvs = 32'd1;
        end
        uq        = dvd / dvs;
        ur        = dvd % dvs;
        quo       = (is_signed && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
        rem       = (is_signed && A[31]) ? (~ur + 32'd1) : ur;
    end

    // Control FSM: loads the pending result at issue, counts down, commits to HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ph    <= 32'd0;
            pl    <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        case (MDOp)
                            3'b000, 3'b001: begin
                                ph    <= prod[63:32];
                                pl    <= prod[31:0];
                                cnt   <= MUL_LOAD;
                                state <= S_MUL;
                                busy  <= 1'b1;
                            end
                            3'b010, 3'b011: begin
                                // Divide by zero re-commits the current HI/LO,
                                // which cannot change while busy.
                                if (div_zero) begin
                                    ph <= HI;
                                    pl <= LO;
                                end else begin
                                    ph <= rem;
                                    pl <= quo;
                                end
                                cnt   <= DIV_LOAD;
                                state <= S_DIV;
                                busy  <= 1'b1;
                            end
                            3'b100:  HI <= A;
                            3'b101:  LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt == '0) begin
                        HI    <= ph;
                        LO    <= pl;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide scheduler for the E-stage of the pipelined CPU. Accepts one multiply/divide/move-to instruction per issue, sequences it over a fixed multi-cycle latency, owns the HI/LO architectural registers and drives the busy/stall signal used by the hazard unit. Start requests are qualified by the exception flush so that an instruction cancelled by an interrupt/exception never changes HI/LO.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue strobe from E-stage, one cycle per instruction
- MDOp  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- flush  in  1  exception/interrupt cancel of the E-stage instruction this cycle
- busy  out  1  registered, high while a mult/div is in flight
- stall  out  1  combinational: busy | (start & ~flush & MDOp∈{000..011})
- HI  out  32  registered HI register
- LO  out  32  registered LO register

## Operation
- Effective issue: go = start & ~flush & ~busy. start while busy is ignored (hazard unit guarantees it does not occur; bench checks it is harmless).
- States: IDLE, MUL, DIV. Counter cnt, width sized to max(MULT_CYCLES, DIV_CYCLES).
- IDLE, go & MDOp=MULT/MULTU: compute 64-bit product into pending regs {ph,pl}; cnt←MULT_CYCLES-1; →MUL; busy←1.
- IDLE, go & MDOp=DIV/DIVU: pl←quotient, ph←remainder; cnt←DIV_CYCLES-1; →DIV; busy←1.
- IDLE, go & MTHI: HI←A at this edge. MTLO: LO←A. State stays IDLE, busy stays 0.
- IDLE, go & reserved MDOp: no state change.
- MUL/DIV: cnt decrements each cycle; when cnt=0: HI←ph, LO←pl, busy←0, →IDLE.
- Arithmetic: MULT signed 32×32→64, MULTU unsigned; HI=upper 32, LO=lower 32.
- DIV signed: quotient truncates toward zero, remainder takes dividend sign. 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy period still runs; HI and LO keep prior values.
- flush only qualifies start; an operation already in flight always completes and commits.
- reset (any state, including mid-operation): state IDLE, cnt=0, busy=0, HI=0, LO=0, pending regs 0; in-flight result discarded.

## Timing
- Issue at edge ending cycle T: busy=1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO take the result at edge ending T+N; new values and busy=0 visible from T+N+1.
- stall is high in cycle T (combinational on start) and T+1 … T+N, so a dependent MFHI/MFLO in D reads the committed value.
- MTHI/MTLO: HI/LO updated at edge ending T, visible in T+1; stall never asserted.
- Back-to-back: a new start in cycle T+N+1 is accepted (no dead cycle).
- flush=1 with start in cycle T: no state change, stall low in T.

## Test plan
- Reset: assert reset 2 cycles mid-DIV -> HI=LO=0, busy=0 next cycle; DIV result never appears.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22, DIV A=5,B=0 -> busy 10 cycles, HI=0x11, LO=0x22 afterwards.
- Flush: start MULT 3×4 with flush=1 -> busy stays 0, stall 0, HI/LO unchanged; MTLO A=0x1234 with flush=1 -> LO unchanged; without flush -> LO=0x1234 next cycle, busy 0.
- Start while busy: MULT 2×3 then DIVU 9/4 issued at busy cycle 2 -> ignored; HI=0, LO=6 after cycle 5; immediate MULTU 1×1 at cycle T+N+1 accepted.
